rr_mux_nto1: RTL and testbench
==============================

// Module: rr_mux_nto1
// PURPOSE
//  Parametrised N-to-1 valid/ready crossbar output port with fair round-robin arbitration.
//  Replaces the fixed lowest-index-priority N-to-1 mux used in the NtoM crossbar.
//  Grant is held stable under backpressure, so no source is starved and no payload is dropped.
//  An optional output register stage breaks the rdy_dst -> rdy_src timing path.
//  Sits one per destination inside the NtoM crossbar.
// PARAMETERS
//  N        3  number of source channels (>=2)
//  W        4  payload width in bits
//  OUT_REG  0  0: combinational output; 1: registered output stage, 1-cycle latency
//  IW       $clog2(N)  index width (localparam, not overridable)
// PORTS
//  clk       in   1    clock; all logic on posedge
//  rst_n     in   1    reset, asynchronous, active-low
//  vld_src   in   N    per-source valid
//  pld_src   in   N*W  per-source payload; source i occupies bits [i*W +: W]
//  rdy_src   out  N    per-source ready; at most one bit set per cycle
//  vld_dst   out  1    destination valid
//  pld_dst   out  W    destination payload
//  idx_dst   out  IW   index of the source whose beat is on pld_dst
//  rdy_dst   in   1    destination ready
// BEHAVIOUR
//  Handshake
//  - Transfer occurs when vld && rdy are both high in the same cycle.
//  - Sources keep vld and pld stable until they transfer.
//  Arbitration
//  - ptr (IW bits, reset 0) is the highest-priority source.
//  - gnt is one-hot: the first i with vld_src[i] set, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
//  - When a source-side transfer from source k occurs, ptr <= (k+1) mod N. Wrap at N-1 -> 0.
//  - If no source-side transfer occurs, ptr holds.
//  Lock
//  - OUT_REG=0: when vld_dst=1 and rdy_dst=0, lock <= 1 and lock_idx <= granted index.
//  - While lock=1, gnt is forced to lock_idx, even if a higher-priority source raises vld.
//  - lock clears on the transfer.
//  OUT_REG=0 (combinational output)
//  - vld_dst = |vld_src
//  - pld_dst = pld_src of the granted source
//  - idx_dst = granted index
//  - rdy_src[i] = gnt[i] & rdy_dst
//  - Latency 0. pld_dst and idx_dst are 0 when no source is valid.
//  OUT_REG=1 (registered output)
//  - Output register holds vld_q, pld_q and idx_q.
//  - en = !vld_q | rdy_dst; rdy_src[i] = gnt[i] & en.
//  - When en=1: vld_q <= |vld_src, pld_q <= granted pld, idx_q <= granted index.
//  - Latency 1 cycle; throughput 1 beat/cycle; vld_dst, pld_dst and idx_dst are registered.
//  - Lock is unused: gnt only matters when en=1, and there it transfers immediately.
//  - When vld_q=0, pld_q and idx_q hold their last values.
//  Reset
//  - ptr=0, lock=0, vld_dst=0, pld_dst=0, idx_dst=0.
//  - rdy_src is combinational: 0 while no source is valid.
//  - Mid-operation reset drops any registered beat and restores priority to source 0 on release.
//  Boundary conditions
//  - All sources valid every cycle: grants rotate 0,1,2,0,...
//  - A single valid source transfers every cycle that rdy_dst=1, regardless of ptr.
//  - rdy_dst held low: no rdy_src asserts (OUT_REG=1 once vld_q=1), ptr frozen, output stable.
//  - Arrival of a new vld during a stall never changes the offered beat.
// TESTING (N=3, W=4)
//  1. vld_src=3'b111, pld=(0xA,0xB,0xC), rdy_dst=1 for 6 cycles
//     -> idx_dst sequence 0,1,2,0,1,2; pld_dst A,B,C,A,B,C.
//     OUT_REG=1: same sequence, shifted by 1 cycle.
//  2. OUT_REG=0, only src2 valid, rdy_dst=0 for 3 cycles; src0 raises vld in cycle 2
//     -> pld_dst stays src2 payload and idx_dst=2 throughout.
//     rdy_dst=1 transfers src2; next grant is src0.
//  3. Only vld_src=3'b010 with rdy_dst=1 for 4 cycles -> 4 transfers from src1; ptr=2 after each.
//  4. ptr=2 with vld_src=3'b011 -> src0 granted (wrap-around), then ptr=1.
//  5. OUT_REG=1, rdy_dst toggling 1,0,1,0 with all sources valid
//     -> no beat lost or duplicated; per-source counts differ by at most 1.
//  6. Assert rst_n=0 mid-stream with vld_q=1
//     -> vld_dst=0 immediately (asynchronous).
//     After release with vld_src=3'b110, the first grant is src1.

Source files
------------

// File: rtl/rr_mux_nto1.sv
// N-to-1 valid/ready output port with round-robin arbitration and grant lock under
// backpressure; OUT_REG=1 adds a skid-free output register stage (1-cycle latency).

module rr_mux_lane #(
    parameter int W = 4
) (
    input  logic         gnt,
    input  logic         en,
    input  logic [W-1:0] pld,
    output logic         rdy,
    output logic [W-1:0] pld_m
);
    assign rdy   = gnt & en;
    assign pld_m = pld & {W{gnt}};
endmodule

module rr_mux_nto1 #(
    parameter int N       = 3,
    parameter int W       = 4,
    parameter bit OUT_REG = 1'b0,
    localparam int IW     = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  vld_src,
    input  logic [N*W-1:0] pld_src,
    output logic [N-1:0]  rdy_src,
    output logic          vld_dst,
    output logic [W-1:0]  pld_dst,
    output logic [IW-1:0] idx_dst,
    input  logic          rdy_dst
);
    logic [IW-1:0]       ptr, lock_idx, arb_idx, gnt_idx, idx_sel;
    logic                lock, arb_any, en, src_xfer;
    logic [N-1:0]        gnt;
    logic [N-1:0][W-1:0] pld_m;
    logic [W-1:0]        pld_sel;

    // Scan from ptr upward with wrap; iterating downward lets the nearest hit win.
    always_comb begin
        int j;
        arb_idx = '0;
        arb_any = 1'b0;
        j       = 0;
        for (int off = N - 1; off >= 0; off--) begin
            j = (int'(ptr) + off) % N;
            if (vld_src[j]) begin
                arb_idx = IW'(j);
                arb_any = 1'b1;
            end
        end
    end

    assign gnt_idx = lock ? lock_idx : arb_idx;
    assign gnt     = arb_any ? (N'(1) << gnt_idx) : '0;
    assign idx_sel = arb_any ? gnt_idx : '0;

    generate
        for (genvar i = 0; i < N; i++) begin : g_lane
            rr_mux_lane #(.W(W)) u_lane (
                .gnt   (gnt[i]),
                .en    (en),
                .pld   (pld_src[i*W +: W]),
                .rdy   (rdy_src[i]),
                .pld_m (pld_m[i])
            );
        end
    endgenerate

    always_comb begin
        pld_sel = '0;
        for (int i = 0; i < N; i++) pld_sel = pld_sel | pld_m[i];
    end

    assign src_xfer = |(vld_src & rdy_src);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (src_xfer) begin
            ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
        end
    end

    // Lock pins the offered beat during a combinational-path stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock     <= 1'b0;
            lock_idx <= '0;
        end else if (src_xfer) begin
            lock <= 1'b0;
        end else if (!OUT_REG && arb_any && !rdy_dst) begin
            lock     <= 1'b1;
            lock_idx <= gnt_idx;
        end
    end

    generate
        if (OUT_REG) begin : g_reg
            logic          vld_q;
            logic [W-1:0]  pld_q;
            logic [IW-1:0] idx_q;

            assign en = !vld_q || rdy_dst;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= 1'b0;
                    pld_q <= '0;
                    idx_q <= '0;
                end else if (en) begin
                    vld_q <= arb_any;
                    if (arb_any) begin
                        pld_q <= pld_sel;
                        idx_q <= idx_sel;
                    end
                end
            end

            assign vld_dst = vld_q;
            assign pld_dst = pld_q;
            assign idx_dst = idx_q;
        end else begin : g_comb
            assign en      = rdy_dst;
            assign vld_dst = arb_any;
            assign pld_dst = pld_sel;
            assign idx_dst = idx_sel;
        end
    endgenerate
endmodule

// File: tb/tb_rr_mux_nto1.sv
// Directed bench for rr_mux_nto1: one combinational and one registered instance share stimulus.

module tb_rr_mux_nto1;
    localparam int N = 3;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   vld_src = '0;
    logic [N*W-1:0] pld_src = 12'hCBA;
    logic           rdy_dst = 1'b0;

    logic [N-1:0] rdy_src0, rdy_src1;
    logic         vld_dst0, vld_dst1;
    logic [W-1:0] pld_dst0, pld_dst1;
    logic [1:0]   idx_dst0, idx_dst1;

    int errs = 0;
    int checks = 0;
    logic [3:0] pv [3] = '{4'hA, 4'hB, 4'hC};

    always #5 clk = ~clk;

    rr_mux_nto1 #(.N(N), .W(W), .OUT_REG(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .vld_src(vld_src), .pld_src(pld_src),
        .rdy_src(rdy_src0), .vld_dst(vld_dst0), .pld_dst(pld_dst0),
        .idx_dst(idx_dst0), .rdy_dst(rdy_dst)
    );

    rr_mux_nto1 #(.N(N), .W(W), .OUT_REG(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .vld_src(vld_src), .pld_src(pld_src),
        .rdy_src(rdy_src1), .vld_dst(vld_dst1), .pld_dst(pld_dst1),
        .idx_dst(idx_dst1), .rdy_dst(rdy_dst)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; vld_src = '0; rdy_dst = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; vld_src = '0; rdy_dst = 1'b0;
        step(); step();
        checks++; if (vld_dst0 !== 1'b0) begin errs++; $display("FAIL rst_vld0 got=%b exp=0", vld_dst0); end
        checks++; if ({vld_dst1, pld_dst1, idx_dst1} !== 7'd0) begin errs++; $display("FAIL rst_out1 got=%h exp=0", {vld_dst1, pld_dst1, idx_dst1}); end
        checks++; if ({rdy_src0, rdy_src1} !== 6'd0) begin errs++; $display("FAIL rst_rdy got=%b exp=0", {rdy_src0, rdy_src1}); end
        checks++; if (dut0.ptr !== 2'd0) begin errs++; $display("FAIL rst_ptr got=%0d exp=0", dut0.ptr); end
        rst_n = 1'b1;
    endtask

    task automatic test_rotate;
        do_reset();
        vld_src = 3'b111; rdy_dst = 1'b1;
        for (int i = 0; i < 7; i++) begin
            #1;
            if (i < 6) begin
                checks++;
                if (idx_dst0 !== 2'(i % 3) || pld_dst0 !== pv[i % 3]) begin
                    errs++; $display("FAIL rot0[%0d] got idx=%0d pld=%h exp idx=%0d pld=%h", i, idx_dst0, pld_dst0, i % 3, pv[i % 3]);
                end
            end
            if (i >= 1) begin
                checks++;
                if (vld_dst1 !== 1'b1 || idx_dst1 !== 2'((i - 1) % 3) || pld_dst1 !== pv[(i - 1) % 3]) begin
                    errs++; $display("FAIL rot1[%0d] got v=%b idx=%0d pld=%h exp idx=%0d pld=%h", i, vld_dst1, idx_dst1, pld_dst1, (i - 1) % 3, pv[(i - 1) % 3]);
                end
            end
            step();
        end
    endtask

    task automatic test_lock;
        do_reset();
        vld_src = 3'b100; rdy_dst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) vld_src = 3'b101;
            #1;
            checks++;
            if (vld_dst0 !== 1'b1 || idx_dst0 !== 2'd2 || pld_dst0 !== 4'hC || rdy_src0 !== 3'b000) begin
                errs++; $display("FAIL lock[%0d] got v=%b idx=%0d pld=%h rdy=%b exp v=1 idx=2 pld=c rdy=000", c, vld_dst0, idx_dst0, pld_dst0, rdy_src0);
            end
            step();
        end
        rdy_dst = 1'b1;
        #1;
        checks++;
        if (rdy_src0 !== 3'b100 || idx_dst0 !== 2'd2) begin
            errs++; $display("FAIL lock_xfer got rdy=%b idx=%0d exp rdy=100 idx=2", rdy_src0, idx_dst0);
        end
        step();
        #1;
        checks++;
        if (rdy_src0 !== 3'b001 || idx_dst0 !== 2'd0 || pld_dst0 !== 4'hA) begin
            errs++; $display("FAIL lock_next got rdy=%b idx=%0d pld=%h exp rdy=001 idx=0 pld=a", rdy_src0, idx_dst0, pld_dst0);
        end
    endtask

    task automatic test_single_and_wrap;
        do_reset();
        vld_src = 3'b010; rdy_dst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (rdy_src0 !== 3'b010 || idx_dst0 !== 2'd1 || pld_dst0 !== 4'hB) begin
                errs++; $display("FAIL single[%0d] got rdy=%b idx=%0d pld=%h exp rdy=010 idx=1 pld=b", c, rdy_src0, idx_dst0, pld_dst0);
            end
            step();
            checks++;
            if (dut0.ptr !== 2'd2) begin errs++; $display("FAIL single_ptr[%0d] got=%0d exp=2", c, dut0.ptr); end
        end
        vld_src = 3'b011;
        #1;
        checks++;
        if (idx_dst0 !== 2'd0 || rdy_src0 !== 3'b001) begin
            errs++; $display("FAIL wrap got idx=%0d rdy=%b exp idx=0 rdy=001", idx_dst0, rdy_src0);
        end
        step();
        checks++;
        if (dut0.ptr !== 2'd1) begin errs++; $display("FAIL wrap_ptr got=%0d exp=1", dut0.ptr); end
        #1;
        checks++;
        if (idx_dst0 !== 2'd1) begin errs++; $display("FAIL wrap_next got idx=%0d exp=1", idx_dst0); end
    endtask

    task automatic test_back_to_back;
        int ld, ox, tot;
        int cnt [3];
        logic exp_vq, en_e;
        do_reset();
        ld = 0; ox = 0; tot = 0; exp_vq = 1'b0;
        cnt = '{0, 0, 0};
        vld_src = 3'b111;
        for (int c = 0; c < 12; c++) begin
            rdy_dst = (c % 2 == 0);
            #1;
            en_e = !exp_vq || rdy_dst;
            checks++;
            if (vld_dst1 !== exp_vq) begin errs++; $display("FAIL b2b_vld[%0d] got=%b exp=%b", c, vld_dst1, exp_vq); end
            checks++;
            if (rdy_src1 !== (en_e ? 3'(1 << ld) : 3'b000)) begin
                errs++; $display("FAIL b2b_rdy[%0d] got=%b exp=%b", c, rdy_src1, en_e ? 3'(1 << ld) : 3'b000);
            end
            if (exp_vq && rdy_dst) begin
                checks++;
                if (idx_dst1 !== 2'(ox) || pld_dst1 !== pv[ox]) begin
                    errs++; $display("FAIL b2b_beat[%0d] got idx=%0d pld=%h exp idx=%0d pld=%h", c, idx_dst1, pld_dst1, ox, pv[ox]);
                end
                cnt[ox]++; tot++; ox = (ox + 1) % 3;
            end
            if (en_e) begin
                ld = (ld + 1) % 3;
                exp_vq = 1'b1;
            end
            step();
        end
        checks++;
        if (tot != 5) begin errs++; $display("FAIL b2b_total got=%0d exp=5", tot); end
        checks++;
        if (cnt[0] - cnt[2] > 1 || cnt[2] - cnt[0] > 1 || cnt[0] - cnt[1] > 1 || cnt[1] - cnt[0] > 1) begin
            errs++; $display("FAIL b2b_fair got=%0d,%0d,%0d exp spread<=1", cnt[0], cnt[1], cnt[2]);
        end
    endtask

    task automatic test_midreset;
        do_reset();
        vld_src = 3'b111; rdy_dst = 1'b0;
        step();
        checks++;
        if (vld_dst1 !== 1'b1) begin errs++; $display("FAIL mr_loaded got=%b exp=1", vld_dst1); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({vld_dst1, pld_dst1, idx_dst1} !== 7'd0) begin
            errs++; $display("FAIL mr_async got=%h exp=0", {vld_dst1, pld_dst1, idx_dst1});
        end
        step();
        vld_src = 3'b110; rdy_dst = 1'b1; rst_n = 1'b1;
        #1;
        checks++;
        if (idx_dst0 !== 2'd1 || rdy_src1 !== 3'b010) begin
            errs++; $display("FAIL mr_first got idx0=%0d rdy1=%b exp idx0=1 rdy1=010", idx_dst0, rdy_src1);
        end
        step();
        checks++;
        if (vld_dst1 !== 1'b1 || idx_dst1 !== 2'd1 || pld_dst1 !== 4'hB) begin
            errs++; $display("FAIL mr_out1 got v=%b idx=%0d pld=%h exp v=1 idx=1 pld=b", vld_dst1, idx_dst1, pld_dst1);
        end
    endtask

    initial begin
        test_reset();
        test_rotate();
        test_lock();
        test_single_and_wrap();
        test_back_to_back();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
